alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 91 +++++++++
 rtl/imm_gen.sv | 31 +++
 rtl/alu_issue_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the decode/issue stage and the ALU:
//   - ALU_OPERATION code constants (the ALU case statement uses the same names)
//   - RV32 major opcode constants
//   - funct7 constants for OP / OP-IMM shift decode
//   - immediate format selector and the ID/EX register payload struct
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes. MUL..REMU are contiguous and in funct3 order,
    // so the M-extension decode is a plain offset from ALU_MUL.
    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_OR     = 5'b00001;
    localparam logic [4:0] ALU_ADD    = 5'b00010;
    localparam logic [4:0] ALU_SUB    = 5'b00011;
    localparam logic [4:0] ALU_SLL    = 5'b00100;
    localparam logic [4:0] ALU_SLT    = 5'b00101;
    localparam logic [4:0] ALU_SLTU   = 5'b00110;
    localparam logic [4:0] ALU_XOR    = 5'b00111;
    localparam logic [4:0] ALU_SRL    = 5'b01000;
    localparam logic [4:0] ALU_SRA    = 5'b01001;
    localparam logic [4:0] ALU_MUL    = 5'b01010;
    localparam logic [4:0] ALU_MULH   = 5'b01011;
    localparam logic [4:0] ALU_MULHSU = 5'b01100;
    localparam logic [4:0] ALU_MULHU  = 5'b01101;
    localparam logic [4:0] ALU_DIV    = 5'b01110;
    localparam logic [4:0] ALU_DIVU   = 5'b01111;
    localparam logic [4:0] ALU_REM    = 5'b10000;
    localparam logic [4:0] ALU_REMU   = 5'b10001;

    // RV32 major opcodes handled by the issue stage
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // ID/EX register payload
    typedef struct packed {
        logic        vld;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic [2:0]  funct3;
        logic [31:0] store_data;
        logic        illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    // funct3 -> ALU code for the base-integer register/immediate ops.
    // 'alt' selects SUB/SRA (funct7=0100000 on OP, imm[11:5] on SRAI).
    function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32 immediate extractor with sign extension.
// Ports:
//   instr_i  in  [31:7] instruction word (opcode bits are not needed)
//   fmt_i    in  imm_fmt_e  immediate format (I/S/B/U/J)
//   imm_o    out [31:0] sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        unique case (fmt_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Decode-to-execute issue stage for RV32IM: decodes the instruction, builds the
// ALU operands and operation code, and registers them in ID/EX.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   IN_VALID                 inputs carry a real instruction
//   INSTRUCTION, PC          instruction word and its address
//   RS1_DATA, RS2_DATA       register operands (forwarding already applied)
//   STALL, FLUSH             hold / bubble the ID/EX register (FLUSH wins)
//   OUT_VALID                ID/EX holds a real instruction
//   DATA1, DATA2             ALU operands
//   ALU_OPERATION            ALU operation code
//   RD_ADDR, REG_WRITE_EN    writeback destination and enable
//   MEM_READ, MEM_WRITE      load / store
//   BRANCH, FUNCT3           conditional branch and its funct3
//   STORE_DATA               store data (RS2_DATA on stores, else 0)
//   ILLEGAL                  unsupported encoding
// All outputs come straight from the ID/EX register.
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [31:0] DATA1,
    output logic [31:0] DATA2,
    output logic [4:0]  ALU_OPERATION,
    output logic [4:0]  RD_ADDR,
    output logic        REG_WRITE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic [2:0]  FUNCT3,
    output logic [31:0] STORE_DATA,
    output logic        ILLEGAL
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] shamt_imm;
    logic [31:0] shamt_reg;

    assign opcode    = INSTRUCTION[6:0];
    assign rd        = INSTRUCTION[11:7];
    assign f3        = INSTRUCTION[14:12];
    assign f7        = INSTRUCTION[31:25];
    assign shamt_imm = {27'b0, INSTRUCTION[24:20]};
    // The ALU shifts by the full DATA2, so register shift amounts are masked here.
    assign shamt_reg = {27'b0, RS2_DATA[4:0]};

    // Immediate format depends on opcode only, kept apart from the decode
    // block so the imm_gen round trip is not a combinational self-loop.
    imm_fmt_e    imm_fmt;
    logic [31:0] imm;

    always_comb begin
        imm_fmt = IMM_I;
        case (opcode)
            OPC_STORE:          imm_fmt = IMM_S;
            OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
            default:            imm_fmt = IMM_I;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i (INSTRUCTION[31:7]),
        .fmt_i   (imm_fmt),
        .imm_o   (imm)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    idex_t dec;
    logic  writes;
    logic  illegal;

    always_comb begin
        dec        = IDEX_BUBBLE;
        dec.vld    = 1'b1;
        dec.funct3 = f3;
        dec.op     = ALU_ADD;
        writes     = 1'b0;
        illegal    = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec.data1 = RS1_DATA;
                dec.data2 = RS2_DATA;
                writes    = 1'b1;
                case (f7)
                    F7_BASE: dec.op = base_op(f3, 1'b0);
                    F7_ALT: begin
                        if (f3 == 3'b000 || f3 == 3'b101) dec.op = base_op(f3, 1'b1);
                        else                              illegal = 1'b1;
                    end
                    F7_MULDIV: dec.op = ALU_MUL + {2'b00, f3};
                    default:   illegal = 1'b1;
                endcase
                // funct3 001/101 are the shifts outside the M extension
                if (f7 != F7_MULDIV && f3[1:0] == 2'b01) dec.data2 = shamt_reg;
            end

            OPC_OP_IMM: begin
                dec.data1 = RS1_DATA;
                dec.data2 = imm;
                dec.op    = base_op(f3, 1'b0);
                writes    = 1'b1;
                if (f3 == 3'b001) begin
                    dec.data2 = shamt_imm;
                    if (f7 != F7_BASE) illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec.data2 = shamt_imm;
                    if (f7 == F7_ALT)       dec.op  = ALU_SRA;
                    else if (f7 != F7_BASE) illegal = 1'b1;
                end
            end

            OPC_LUI: begin
                dec.data1 = '0;
                dec.data2 = imm;
                writes    = 1'b1;
            end

            OPC_AUIPC: begin
                dec.data1 = PC;
                dec.data2 = imm;
                writes    = 1'b1;
            end

            // Link value PC+4; the jump target is computed elsewhere.
            OPC_JAL, OPC_JALR: begin
                dec.data1 = PC;
                dec.data2 = 32'd4;
                writes    = 1'b1;
            end

            OPC_LOAD: begin
                dec.data1  = RS1_DATA;
                dec.data2  = imm;
                dec.mem_rd = 1'b1;
                writes     = 1'b1;
            end

            OPC_STORE: begin
                dec.data1      = RS1_DATA;
                dec.data2      = imm;
                dec.mem_wr     = 1'b1;
                dec.store_data = RS2_DATA;
            end

            OPC_BRANCH: begin
                dec.data1  = RS1_DATA;
                dec.data2  = RS2_DATA;
                dec.branch = 1'b1;
                case (f3[2:1])
                    2'b00:   dec.op  = ALU_SUB;   // BEQ/BNE
                    2'b10:   dec.op  = ALU_SLT;   // BLT/BGE
                    2'b11:   dec.op  = ALU_SLTU;  // BLTU/BGEU
                    default: illegal = 1'b1;
                endcase
            end

            default: illegal = 1'b1;
        endcase

        dec.rd = writes ? rd : 5'd0;
        dec.we = writes && (rd != 5'd0);

        if (illegal) begin
            dec         = IDEX_BUBBLE;
            dec.vld     = 1'b1;
            dec.illegal = 1'b1;
            dec.op      = ALU_ADD;
            dec.funct3  = f3;
        end

        if (!IN_VALID) dec = IDEX_BUBBLE;
    end

    // ------------------------------------------------------------------
    // ID/EX register: RESET > FLUSH > STALL > load
    // ------------------------------------------------------------------
    idex_t idex_d;
    idex_t idex_q;

    always_comb begin
        idex_d = dec;
        if (FLUSH)      idex_d = IDEX_BUBBLE;
        else if (STALL) idex_d = idex_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) idex_q <= IDEX_BUBBLE;
        else       idex_q <= idex_d;
    end

    assign OUT_VALID     = idex_q.vld;
    assign DATA1         = idex_q.data1;
    assign DATA2         = idex_q.data2;
    assign ALU_OPERATION = idex_q.op;
    assign RD_ADDR       = idex_q.rd;
    assign REG_WRITE_EN  = idex_q.we;
    assign MEM_READ      = idex_q.mem_rd;
    assign MEM_WRITE     = idex_q.mem_wr;
    assign BRANCH        = idex_q.branch;
    assign FUNCT3        = idex_q.funct3;
    assign STORE_DATA    = idex_q.store_data;
    assign ILLEGAL       = idex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed scenarios plus randomized instructions with random STALL/FLUSH/RESET,
// compared against a mnemonic-level reference model of the issue stage.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, STALL, FLUSH;
    logic [31:0] INSTRUCTION, PC, RS1_DATA, RS2_DATA;
    logic        OUT_VALID, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, ILLEGAL;
    logic [31:0] DATA1, DATA2, STORE_DATA;
    logic [4:0]  ALU_OPERATION, RD_ADDR;
    logic [2:0]  FUNCT3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_issue_stage dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTRUCTION(INSTRUCTION),
        .PC(PC), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .STALL(STALL), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .DATA1(DATA1), .DATA2(DATA2), .ALU_OPERATION(ALU_OPERATION),
        .RD_ADDR(RD_ADDR), .REG_WRITE_EN(REG_WRITE_EN), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .BRANCH(BRANCH), .FUNCT3(FUNCT3), .STORE_DATA(STORE_DATA),
        .ILLEGAL(ILLEGAL)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        mr;
        logic        mw;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    // funct3 -> ALU code for ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND
    localparam logic [4:0] BASE_OP [8] = '{5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd1, 5'd0};

    function automatic exp_t obs();
        exp_t o;
        o.vld = OUT_VALID;    o.d1 = DATA1;      o.d2 = DATA2;
        o.op  = ALU_OPERATION; o.rd = RD_ADDR;   o.we = REG_WRITE_EN;
        o.mr  = MEM_READ;     o.mw = MEM_WRITE;  o.br = BRANCH;
        o.f3  = FUNCT3;       o.sd = STORE_DATA; o.ill = ILLEGAL;
        return o;
    endfunction

    // Reference model: what ID/EX should hold after loading this instruction.
    function automatic exp_t model(input logic v, input logic [31:0] ins,
                                   input logic [31:0] pc, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rdf;
        logic [31:0] iimm, simm, uimm;
        logic wr, ill;
        e = '0;
        if (!v) return e;
        f3 = ins[14:12]; f7 = ins[31:25]; rdf = ins[11:7];
        iimm = {{20{ins[31]}}, ins[31:20]};
        simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        uimm = {ins[31:12], 12'h000};
        wr = 1'b0; ill = 1'b0;
        e.vld = 1'b1; e.f3 = f3; e.op = 5'd2;
        case (ins[6:0])
            7'h33: begin
                e.d1 = a; e.d2 = b; wr = 1'b1;
                if (f7 == 7'h00)                  e.op = BASE_OP[f3];
                else if (f7 == 7'h20 && f3 == 0)  e.op = 5'd3;
                else if (f7 == 7'h20 && f3 == 5)  e.op = 5'd9;
                else if (f7 == 7'h01)             e.op = 5'd10 + 5'(f3);
                else                              ill = 1'b1;
                if (e.op == 5'd4 || e.op == 5'd8 || e.op == 5'd9) e.d2 = b % 32;
            end
            7'h13: begin
                e.d1 = a; wr = 1'b1;
                if (f3 == 1) begin
                    e.d2 = 32'(ins[24:20]);
                    if (f7 == 7'h00) e.op = 5'd4; else ill = 1'b1;
                end else if (f3 == 5) begin
                    e.d2 = 32'(ins[24:20]);
                    if (f7 == 7'h00)      e.op = 5'd8;
                    else if (f7 == 7'h20) e.op = 5'd9;
                    else                  ill = 1'b1;
                end else begin
                    e.op = BASE_OP[f3]; e.d2 = iimm;
                end
            end
            7'h37: begin e.d1 = 0;  e.d2 = uimm; wr = 1'b1; end
            7'h17: begin e.d1 = pc; e.d2 = uimm; wr = 1'b1; end
            7'h6F, 7'h67: begin e.d1 = pc; e.d2 = 4; wr = 1'b1; end
            7'h03: begin e.d1 = a; e.d2 = iimm; e.mr = 1'b1; wr = 1'b1; end
            7'h23: begin e.d1 = a; e.d2 = simm; e.mw = 1'b1; e.sd = b; end
            7'h63: begin
                e.d1 = a; e.d2 = b; e.br = 1'b1;
                if (f3 == 2 || f3 == 3) ill = 1'b1;
                else e.op = (f3 < 2) ? 5'd3 : (f3 < 6) ? 5'd5 : 5'd6;
            end
            default: ill = 1'b1;
        endcase
        if (wr) begin e.rd = rdf; e.we = (rdf != 0); end
        if (ill) begin
            e = '0; e.vld = 1'b1; e.ill = 1'b1; e.op = 5'd2; e.f3 = f3;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  opc, f7;
        int k, s;
        r = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h37; 3: opc = 7'h17;
            4: opc = 7'h6F; 5: opc = 7'h67; 6: opc = 7'h03; 7: opc = 7'h23;
            8: opc = 7'h63; default: opc = r[6:0];
        endcase
        s = $urandom_range(0, 3);
        f7 = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : (s == 2) ? 7'h01 : r[31:25];
        r[6:0] = opc;
        if (opc == 7'h33 || (opc == 7'h13 && r[13:12] == 2'b01)) r[31:25] = f7;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        IN_VALID = v; INSTRUCTION = ins; PC = pc; RS1_DATA = a; RS2_DATA = b;
    endtask

    task automatic test_reset();
        exp_t got;
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        drive(1'b1, 32'h00208193, 32'h100, 32'h5, 32'h6);
        tick(); tick();
        got = obs();
        checks++;
        if (got !== exp_t'('0)) begin
            errors++; $display("FAIL reset_state got=%h exp=0", got);
        end
        RESET = 1'b0;
    endtask

    task automatic test_addi();
        drive(1'b1, 32'hFFF08293, 32'h200, 32'h10, 32'h0);
        tick();
        checks++;
        if ({OUT_VALID, DATA1, DATA2, ALU_OPERATION, RD_ADDR, REG_WRITE_EN} !==
            {1'b1, 32'h10, 32'hFFFFFFFF, 5'b00010, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL addi got v=%b d1=%h d2=%h op=%b rd=%0d we=%b exp 1 10 ffffffff 00010 5 1",
                     OUT_VALID, DATA1, DATA2, ALU_OPERATION, RD_ADDR, REG_WRITE_EN);
        end
    endtask

    task automatic test_shifts();
        drive(1'b1, 32'h4033D313, 32'h204, 32'h80000000, 32'h0);
        tick();
        checks++;
        if ({DATA2, ALU_OPERATION} !== {32'h3, 5'b01001}) begin
            errors++; $display("FAIL srai got d2=%h op=%b exp 00000003 01001", DATA2, ALU_OPERATION);
        end
        // SLL x3,x1,x2
        drive(1'b1, 32'h002091B3, 32'h208, 32'h1, 32'hFFFFFF25);
        tick();
        checks++;
        if ({DATA2, ALU_OPERATION} !== {32'h5, 5'b00100}) begin
            errors++; $display("FAIL sll got d2=%h op=%b exp 00000005 00100", DATA2, ALU_OPERATION);
        end
    endtask

    task automatic test_lui_mul();
        drive(1'b1, 32'h123450B7, 32'h20C, 32'hDEAD, 32'hBEEF);
        tick();
        checks++;
        if ({DATA1, DATA2, ALU_OPERATION} !== {32'h0, 32'h12345000, 5'b00010}) begin
            errors++; $display("FAIL lui got d1=%h d2=%h op=%b exp 0 12345000 00010",
                               DATA1, DATA2, ALU_OPERATION);
        end
        drive(1'b1, 32'h023100B3, 32'h210, 32'h7, 32'h9);
        tick();
        checks++;
        if (ALU_OPERATION !== 5'b01010) begin
            errors++; $display("FAIL mul got op=%b exp 01010", ALU_OPERATION);
        end
    endtask

    task automatic test_branch_illegal();
        // BLTU x1,x2,+8
        drive(1'b1, 32'h0020E463, 32'h300, 32'h1, 32'h2);
        tick();
        checks++;
        if ({ALU_OPERATION, BRANCH, FUNCT3, REG_WRITE_EN} !== {5'b00110, 1'b1, 3'b110, 1'b0}) begin
            errors++; $display("FAIL bltu got op=%b br=%b f3=%b we=%b exp 00110 1 110 0",
                               ALU_OPERATION, BRANCH, FUNCT3, REG_WRITE_EN);
        end
        drive(1'b1, 32'h0000007F, 32'h304, 32'h1, 32'h2);
        tick();
        checks++;
        if ({OUT_VALID, ILLEGAL, DATA1, DATA2, ALU_OPERATION, REG_WRITE_EN, MEM_READ,
             MEM_WRITE, BRANCH} !== {1'b1, 1'b1, 32'h0, 32'h0, 5'b00010, 4'b0000}) begin
            errors++; $display("FAIL illegal got v=%b ill=%b d1=%h d2=%h op=%b we/mr/mw/br=%b%b%b%b",
                               OUT_VALID, ILLEGAL, DATA1, DATA2, ALU_OPERATION,
                               REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH);
        end
    endtask

    task automatic test_stall_flush();
        exp_t exp_add, got;
        exp_add = model(1'b1, 32'h002081B3, 32'h400, 32'h11, 32'h22);
        drive(1'b1, 32'h002081B3, 32'h400, 32'h11, 32'h22);
        tick();
        got = obs();
        checks++;
        if (got !== exp_add) begin
            errors++; $display("FAIL add_load got=%h exp=%h", got, exp_add);
        end
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h0000007F + 32'(i), 32'h500 + 32'(i), $urandom(), $urandom());
            tick();
            got = obs();
            checks++;
            if (got !== exp_add) begin
                errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp_add);
            end
        end
        FLUSH = 1'b1;
        tick();
        checks++;
        if ({OUT_VALID, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, ILLEGAL} !== 6'b0) begin
            errors++; $display("FAIL flush_stall got v=%b we=%b mr=%b mw=%b br=%b ill=%b exp all 0",
                               OUT_VALID, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, ILLEGAL);
        end
        STALL = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic test_reset_drop();
        exp_t got, exp_lui;
        drive(1'b1, 32'hFFF08293, 32'h600, 32'h10, 32'h0);
        RESET = 1'b1;
        tick();
        got = obs();
        checks++;
        if (got !== exp_t'('0)) begin
            errors++; $display("FAIL reset_drop got=%h exp=0", got);
        end
        RESET = 1'b0;
        drive(1'b1, 32'h123450B7, 32'h604, 32'h0, 32'h0);
        exp_lui = model(1'b1, 32'h123450B7, 32'h604, 32'h0, 32'h0);
        tick();
        got = obs();
        checks++;
        if (got !== exp_lui) begin
            errors++; $display("FAIL after_reset got=%h exp=%h", got, exp_lui);
        end
    endtask

    task automatic test_random();
        exp_t st, got;
        logic [31:0] ins, pcv, a, b;
        logic v, stl, fl, rst;
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        tick();
        RESET = 1'b0;
        st = '0;
        for (int i = 0; i < 400; i++) begin
            ins = gen_instr();
            pcv = $urandom() & 32'hFFFFFFFC;
            a   = $urandom();
            b   = $urandom();
            v   = ($urandom_range(0, 9) != 0);
            stl = ($urandom_range(0, 6) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            drive(v, ins, pcv, a, b);
            STALL = stl; FLUSH = fl; RESET = rst;
            if (rst || fl) st = '0;
            else if (!stl) st = model(v, ins, pcv, a, b);
            tick();
            got = obs();
            checks++;
            if (got !== st) begin
                errors++;
                $display("FAIL random[%0d] ins=%h v=%b s=%b f=%b r=%b got=%h exp=%h",
                         i, ins, v, stl, fl, rst, got, st);
            end
        end
        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_shifts();
        test_lui_mul();
        test_branch_illegal();
        test_stall_flush();
        test_reset_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
